// File: rtl/ldseq6_pkg.sv
// Shared types and constants for the ldseq6 load sequencer.
// Build option LDSEQ6_COALESCE_EN is consumed by ldseq6_fifo.
package ldseq6_pkg;

  localparam int LDSEQ6_W     = 6;
  localparam int LDSEQ6_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } ldseq6_state_e;

endpackage

// File: rtl/ldseq6_if.sv
// Write handshake plus load/status bus of ldseq6.
// Handshake: a word transfers on the rising edge where wr & ready are both 1.
interface ldseq6_if;
  import ldseq6_pkg::*;

  logic                wr;
  logic [LDSEQ6_W-1:0] din;
  logic                ready;
  logic                ld;
  logic [LDSEQ6_W-1:0] d;
  logic                empty;
  logic                full;
  logic                ovf;

  modport master (
    output wr, din,
    input  ready, ld, d, empty, full, ovf
  );

  modport slave (
    input  wr, din,
    output ready, ld, d, empty, full, ovf
  );

endinterface

// File: rtl/ldseq6_fifo.sv
// Two-entry word buffer with registered full/empty and sticky overflow.
// Build option LDSEQ6_COALESCE_EN: never stall, overwrite the tail entry when full.
module ldseq6_fifo
  import ldseq6_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic [LDSEQ6_W-1:0] din,
  input  logic                pop,
  output logic [LDSEQ6_W-1:0] dout,
  output logic                ready,
  output logic                full,
  output logic                empty,
  output logic                ovf
);

  logic [LDSEQ6_W-1:0] mem_q [LDSEQ6_DEPTH];
  logic [LDSEQ6_W-1:0] mem_d [LDSEQ6_DEPTH];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                push;
  logic                pop_ok;
  logic                overwrite;

`ifdef LDSEQ6_COALESCE_EN
  // A full write lands normally if a pop frees a slot the same cycle.
  assign push      = wr & (~full_q | pop_ok);
  assign overwrite = wr & full_q & ~pop_ok;
  assign ready     = 1'b1;
  assign ovf       = 1'b0;
`else
  logic ovf_q, ovf_d;

  assign push      = wr & ~full_q;
  assign overwrite = 1'b0;
  assign ready     = ~full_q;
  assign ovf       = ovf_q;
  assign ovf_d     = ovf_q | (wr & full_q);

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
`endif

  assign pop_ok = pop & ~empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    // Tail is the slot just behind the write pointer.
    if (overwrite) begin
      mem_d[~wr_ptr_q] = din;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    full_d  = (count_d == 2'd2);
    empty_d = (count_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LDSEQ6_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ldseq6.sv
// Load sequencer: buffers written words and replays them as spaced ld strobes.
// Build option LDSEQ6_COALESCE_EN selects overwrite-on-full in ldseq6_fifo.
module ldseq6
  import ldseq6_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic          sys_clk,
  input  logic          resetl,
  ldseq6_if.slave       bus,
  output ldseq6_state_e dbg_state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_HOLD = HOLD;
  localparam logic [3:0] GAP_M1 = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  logic [1:0]          state_q, state_d;
  logic [3:0]          gcnt_q, gcnt_d;
  logic                ld_q, ld_d;
  logic [LDSEQ6_W-1:0] d_q, d_d;
  logic                pop;
  logic [LDSEQ6_W-1:0] head;
  logic                fifo_empty;

  ldseq6_fifo u_fifo (
    .clk   (sys_clk),
    .rst_n (resetl),
    .wr    (bus.wr),
    .din   (bus.din),
    .pop   (pop),
    .dout  (head),
    .ready (bus.ready),
    .full  (bus.full),
    .empty (fifo_empty),
    .ovf   (bus.ovf)
  );

  // Every transition into LOAD pops the head and registers it onto d.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    ld_d    = 1'b0;
    d_d     = d_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          ld_d    = 1'b1;
          d_d     = head;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (GAP == 0) begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            ld_d = 1'b1;
            d_d  = head;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d  = GAP_M1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (gcnt_q == 4'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            ld_d    = 1'b1;
            d_d     = head;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      gcnt_q  <= 4'd0;
      ld_q    <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      ld_q    <= ld_d;
      d_q     <= d_d;
    end
  end

  assign bus.ld    = ld_q;
  assign bus.d     = d_q;
  assign bus.empty = fifo_empty;
  assign dbg_state = ldseq6_state_e'(state_q);

endmodule

// File: tb/tb_ldseq6.sv
// Directed bench for ldseq6 (GAP=2); expectations adapt to LDSEQ6_COALESCE_EN.
module tb_ldseq6;
  import ldseq6_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic resetl;
  always #5 clk = ~clk;

  ldseq6_if      bus_if ();
  ldseq6_state_e dbg_state;

  ldseq6 #(.GAP(2)) dut (
    .sys_clk   (clk),
    .resetl    (resetl),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // cyc is the index of the cycle currently in progress (stable at negedge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: observed strobes vs expected strobes (data + cycle)
  logic [5:0] got_q[$];
  int         got_c[$];
  logic [5:0] exp_q[$];
  int         exp_c[$];

  always @(negedge clk) begin
    if (resetl && bus_if.ld) begin
      got_q.push_back(bus_if.d);
      got_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_ld(input logic [5:0] data, input int at);
    exp_q.push_back(data);
    exp_c.push_back(at);
  endtask

  task automatic check_loads(input string tag);
    chk($sformatf("%s_nld", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_d%0d", tag, i), got_q[i], exp_q[i]);
        chk($sformatf("%s_cyc%0d", tag, i), got_c[i], exp_c[i]);
      end
    end
    got_q.delete(); got_c.delete(); exp_q.delete(); exp_c.delete();
  endtask

  // driver: caller sits at a negedge; returns the cycle the word transferred in
  task automatic wr_word(input logic [5:0] data, output int acc);
    int w;
    bus_if.wr  = 1'b1;
    bus_if.din = data;
    w = 0;
    while (!bus_if.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 32'd0, 32'd1);
    acc = cyc;
    @(negedge clk);
    bus_if.wr = 1'b0;
  endtask

  task automatic wr_force(input logic [5:0] data);
    bus_if.wr  = 1'b1;
    bus_if.din = data;
    @(negedge clk);
    bus_if.wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t;
    bus_if.wr  = 1'b0;
    bus_if.din = '0;
    resetl     = 1'b0;
    idle(2);

    chk("rst_ld",    bus_if.ld,    1'b0);
    chk("rst_d",     bus_if.d,     6'h00);
    chk("rst_empty", bus_if.empty, 1'b1);
    chk("rst_full",  bus_if.full,  1'b0);
    chk("rst_ready", bus_if.ready, 1'b1);
    chk("rst_ovf",   bus_if.ovf,   1'b0);
    chk("rst_state", dbg_state,    IDLE);
    resetl = 1'b1;
    idle(1);

    // single write: strobe two cycles after the write cycle, d holds afterwards
    wr_word(6'h2A, n);
    expect_ld(6'h2A, n + 2);
    idle(6);
    check_loads("single");
    chk("single_empty", bus_if.empty, 1'b1);
    chk("single_d_hold", bus_if.d, 6'h2A);
    chk("single_ld_low", bus_if.ld, 1'b0);

    // burst of three: strobes GAP+1 = 3 cycles apart, FIFO fills after third
    wr_word(6'h01, n);
    wr_word(6'h02, t);
    wr_word(6'h03, t);
    chk("burst_acc3", t, n + 2);
    chk("burst_full", bus_if.full, 1'b1);
`ifdef LDSEQ6_COALESCE_EN
    chk("burst_ready", bus_if.ready, 1'b1);
`else
    chk("burst_ready", bus_if.ready, 1'b0);
`endif
    expect_ld(6'h01, n + 2);
    expect_ld(6'h02, n + 5);
    expect_ld(6'h03, n + 8);
    idle(12);
    check_loads("burst");
    chk("burst_empty", bus_if.empty, 1'b1);
    chk("burst_ready_back", bus_if.ready, 1'b1);

    // overflow: FIFO holds 11,12 while FSM is in HOLD, then 13 is forced in
    wr_word(6'h10, n);
    wr_word(6'h11, t);
    wr_word(6'h12, t);
    chk("ovf_full", bus_if.full, 1'b1);
    chk("ovf_state", dbg_state, HOLD);
    wr_force(6'h13);
    expect_ld(6'h10, n + 2);
    expect_ld(6'h11, n + 5);
`ifdef LDSEQ6_COALESCE_EN
    expect_ld(6'h13, n + 8);
    chk("ovf_flag", bus_if.ovf, 1'b0);
`else
    expect_ld(6'h12, n + 8);
    chk("ovf_flag", bus_if.ovf, 1'b1);
`endif
    idle(12);
    check_loads("ovf");
`ifdef LDSEQ6_COALESCE_EN
    chk("ovf_sticky", bus_if.ovf, 1'b0);
`else
    chk("ovf_sticky", bus_if.ovf, 1'b1);
`endif

    // reset during HOLD with one entry buffered; wr during reset is ignored
    wr_word(6'h20, n);
    wr_word(6'h21, t);
    wr_word(6'h22, t);
    idle(3);
    chk("mid_state", dbg_state, HOLD);
    chk("mid_empty", bus_if.empty, 1'b0);
    chk("mid_full",  bus_if.full,  1'b0);
    resetl     = 1'b0;
    bus_if.wr  = 1'b1;
    bus_if.din = 6'h15;
    idle(2);
    bus_if.wr = 1'b0;
    resetl    = 1'b1;
    chk("mid_rst_empty", bus_if.empty, 1'b1);
    chk("mid_rst_ovf",   bus_if.ovf,   1'b0);
    chk("mid_rst_ld",    bus_if.ld,    1'b0);
    chk("mid_rst_d",     bus_if.d,     6'h00);
    expect_ld(6'h20, n + 2);
    expect_ld(6'h21, n + 5);
    idle(4);
    check_loads("mid");

    wr_word(6'h3F, n);
    expect_ld(6'h3F, n + 2);
    idle(5);
    check_loads("post");
    chk("post_empty", bus_if.empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
